// File: rtl/mem_port_arb_pkg.sv
// Shared types and encodings for the memory port arbiter and its lane aligner.
package mem_port_arb_pkg;

    // Arbiter states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_ACC = 2'd1,
        ST_D_ACC  = 2'd2
    } state_e;

    // d_size encodings (2'b11 is illegal)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Byte-lane select values (address bits [1:0])
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // Byte-enable patterns
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables, write-data replication,
// misalignment detection, and load lane extraction with sign/zero extension.
module mem_lane_align
    import mem_port_arb_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_lane,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic        misalign_c,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_uns,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Request side: lane enables, replicated write data, alignment check
    always_comb begin
        be_c       = '0;
        wdata_c    = '0;
        misalign_c = 1'b0;
        case (req_size)
            SZ_B: begin
                be_c    = 4'(4'b0001 << req_lane);
                wdata_c = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                be_c       = req_lane[1] ? BE_HI_HALF : BE_LO_HALF;
                wdata_c    = {2{req_wdata[15:0]}};
                misalign_c = req_lane[0];
            end
            SZ_W: begin
                be_c       = BE_ALL;
                wdata_c    = req_wdata;
                misalign_c = (req_lane != LANE0);
            end
            default: misalign_c = 1'b1;
        endcase
    end

    // Load side: move the addressed lane to bit 0 and extend
    always_comb begin
        byte_sel = ld_word[31:24];
        case (ld_lane)
            LANE0:   byte_sel = ld_word[7:0];
            LANE1:   byte_sel = ld_word[15:8];
            LANE2:   byte_sel = ld_word[23:16];
            LANE3:   byte_sel = ld_word[31:24];
            default: byte_sel = ld_word[31:24];
        endcase
        half_sel = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            SZ_B:    ld_data_c = ld_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    ld_data_c = ld_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_data_c = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates a fetch port and a data port onto one memory port; data wins ties.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_uns,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_misalign,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ready
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_e            state_q, state_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [31:0]       m_wdata_q, m_wdata_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic [1:0]        ld_lane_q, ld_lane_d;
    logic              ld_uns_q, ld_uns_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              d_misalign_q, d_misalign_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic              misalign_c;
    logic [31:0]       ld_data_c;

    mem_lane_align u_align (
        .req_size   (d_size),
        .req_lane   (d_addr[1:0]),
        .req_wdata  (d_wdata),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .misalign_c (misalign_c),
        .ld_size    (ld_size_q),
        .ld_lane    (ld_lane_q),
        .ld_uns     (ld_uns_q),
        .ld_word    (m_rdata),
        .ld_data_c  (ld_data_c)
    );

    // Next-state, access latching and completion handling
    always_comb begin
        state_d      = state_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_be_d       = m_be_q;
        m_wdata_d    = m_wdata_q;
        ld_size_d    = ld_size_q;
        ld_lane_d    = ld_lane_q;
        ld_uns_d     = ld_uns_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        d_misalign_d = 1'b0;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                // A rejected data request is still visible during its gnt cycle;
                // skip that cycle so it is not accepted a second time.
                if (!d_gnt_q) begin
                    if (d_req) begin
                        d_gnt_d = 1'b1;
                        if (misalign_c) begin
                            d_misalign_d = 1'b1;
                        end else begin
                            state_d   = ST_D_ACC;
                            m_req_d   = 1'b1;
                            m_we_d    = d_we;
                            m_addr_d  = d_addr & WORD_MASK;
                            m_be_d    = be_c;
                            m_wdata_d = d_we ? wdata_c : 32'd0;
                            ld_size_d = d_size;
                            ld_lane_d = d_addr[1:0];
                            ld_uns_d  = d_uns;
                        end
                    end else if (if_req) begin
                        state_d   = ST_IF_ACC;
                        if_gnt_d  = 1'b1;
                        m_req_d   = 1'b1;
                        m_we_d    = 1'b0;
                        m_addr_d  = if_addr & WORD_MASK;
                        m_be_d    = BE_ALL;
                        m_wdata_d = 32'd0;
                    end
                end
            end
            ST_IF_ACC: begin
                if (m_ready) begin
                    state_d     = ST_IDLE;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = m_rdata;
                end
            end
            ST_D_ACC: begin
                if (m_ready) begin
                    state_d    = ST_IDLE;
                    d_rvalid_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = ld_data_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Memory-side fields return to zero whenever no access is active
        if (state_q != ST_IDLE && m_ready) begin
            m_req_d   = 1'b0;
            m_we_d    = 1'b0;
            m_addr_d  = '0;
            m_be_d    = '0;
            m_wdata_d = '0;
            ld_size_d = '0;
            ld_lane_d = '0;
            ld_uns_d  = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_be_q       <= '0;
            m_wdata_q    <= '0;
            ld_size_q    <= '0;
            ld_lane_q    <= '0;
            ld_uns_q     <= 1'b0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            d_misalign_q <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_be_q       <= m_be_d;
            m_wdata_q    <= m_wdata_d;
            ld_size_q    <= ld_size_d;
            ld_lane_q    <= ld_lane_d;
            ld_uns_q     <= ld_uns_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            d_misalign_q <= d_misalign_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_gnt     = if_gnt_q;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign d_gnt      = d_gnt_q;
    assign d_rvalid   = d_rvalid_q;
    assign d_rdata    = d_rdata_q;
    assign d_misalign = d_misalign_q;
    assign m_req      = m_req_q;
    assign m_we       = m_we_q;
    assign m_addr     = m_addr_q;
    assign m_be       = m_be_q;
    assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with hand-computed expected values.
module tb_mem_port_arb;
    import mem_port_arb_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_uns;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_misalign;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_be;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              m_ready;

    int n_total = 0;
    int n_pass  = 0;

    mem_port_arb #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_uns      (d_uns),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_misalign (d_misalign),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_be       (m_be),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic d_issue(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_size  = sz;
        d_uns   = uns;
        d_addr  = addr;
        d_wdata = wd;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_size = SZ_W; d_uns = 1'b0; d_addr = '0; d_wdata = '0;
        m_rdata = '0; m_ready = 1'b0;
        step(); step();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_gnts", {29'd0, if_gnt, d_gnt, d_misalign}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        chk("rst_m_be", 32'(m_be), 32'd0);
        rst = 1'b0;

        // Fetch at 0x100 (low address bits ignored), one wait cycle
        if_req = 1'b1; if_addr = 32'h0000_0102;
        step();
        chk("if_gnt", 32'(if_gnt), 32'd1);
        chk("if_m_req", 32'(m_req), 32'd1);
        chk("if_m_addr", m_addr, 32'h0000_0100);
        chk("if_m_be", 32'(m_be), 32'hF);
        chk("if_m_we", 32'(m_we), 32'd0);
        if_req = 1'b0;
        step();
        chk("if_gnt_pulse", 32'(if_gnt), 32'd0);
        chk("if_m_req_hold", 32'(m_req), 32'd1);
        m_ready = 1'b1; m_rdata = 32'h0050_0093;
        step();
        chk("if_rvalid", 32'(if_rvalid), 32'd1);
        chk("if_rdata", if_rdata, 32'h0050_0093);
        chk("if_m_req_drop", 32'(m_req), 32'd0);
        chk("if_m_be_idle", 32'(m_be), 32'd0);
        m_ready = 1'b0; m_rdata = 32'h0;
        step();
        chk("if_rvalid_pulse", 32'(if_rvalid), 32'd0);
        chk("if_rdata_hold", if_rdata, 32'h0050_0093);

        // Signed byte load at 0x203; address change after grant is ignored
        d_issue(1'b0, SZ_B, 1'b0, 32'h0000_0203, 32'h0);
        step();
        chk("lb_gnt", 32'(d_gnt), 32'd1);
        chk("lb_misalign", 32'(d_misalign), 32'd0);
        chk("lb_m_be", 32'(m_be), 32'h8);
        chk("lb_m_addr", m_addr, 32'h0000_0200);
        d_req = 1'b0; d_addr = 32'h0; d_uns = 1'b1;
        m_ready = 1'b1; m_rdata = 32'h80FF_1234;
        #1;
        chk("lb_m_be_latched", 32'(m_be), 32'h8);
        step();
        chk("lb_rvalid", 32'(d_rvalid), 32'd1);
        chk("lb_rdata", d_rdata, 32'hFFFF_FF80);
        m_ready = 1'b0;

        // Same byte load, zero-extended
        d_issue(1'b0, SZ_B, 1'b1, 32'h0000_0203, 32'h0);
        step();
        chk("lbu_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0; m_ready = 1'b1;
        step();
        chk("lbu_rdata", d_rdata, 32'h0000_0080);
        m_ready = 1'b0;

        // Unsigned byte at lane 1, signed half at upper lanes
        d_issue(1'b0, SZ_B, 1'b1, 32'h0000_0201, 32'h0);
        step();
        chk("lbu1_m_be", 32'(m_be), 32'h2);
        d_req = 1'b0; m_ready = 1'b1;
        step();
        chk("lbu1_rdata", d_rdata, 32'h0000_0012);
        m_ready = 1'b0;
        d_issue(1'b0, SZ_H, 1'b0, 32'h0000_0202, 32'h0);
        step();
        chk("lh_m_be", 32'(m_be), 32'hC);
        d_req = 1'b0; m_ready = 1'b1;
        step();
        chk("lh_rdata", d_rdata, 32'hFFFF_80FF);
        m_ready = 1'b0;

        // Half store 0x1234 at 0x202, zero wait states
        d_issue(1'b1, SZ_H, 1'b0, 32'h0000_0202, 32'h0000_1234);
        step();
        chk("sh_gnt", 32'(d_gnt), 32'd1);
        chk("sh_m_be", 32'(m_be), 32'hC);
        chk("sh_m_wdata", m_wdata, 32'h1234_1234);
        chk("sh_m_we", 32'(m_we), 32'd1);
        d_req = 1'b0; m_ready = 1'b1; m_rdata = 32'hAAAA_AAAA;
        step();
        chk("sh_rvalid", 32'(d_rvalid), 32'd1);
        chk("sh_rdata_keep", d_rdata, 32'hFFFF_80FF);
        chk("sh_m_we_idle", 32'(m_we), 32'd0);
        m_ready = 1'b0;

        // Byte store replication
        d_issue(1'b1, SZ_B, 1'b0, 32'h0000_0201, 32'h0000_03A5);
        step();
        chk("sb_m_be", 32'(m_be), 32'h2);
        chk("sb_m_wdata", m_wdata, 32'hA5A5_A5A5);
        d_req = 1'b0; m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Misaligned word load at 0x201
        d_issue(1'b0, SZ_W, 1'b0, 32'h0000_0201, 32'h0);
        step();
        chk("mis_w_flags", {30'd0, d_gnt, d_misalign}, 32'd3);
        chk("mis_w_m_req", 32'(m_req), 32'd0);
        d_req = 1'b0;
        step();
        chk("mis_w_after", {28'd0, d_gnt, d_misalign, d_rvalid, m_req}, 32'd0);
        step();
        chk("mis_w_no_rvalid", 32'(d_rvalid), 32'd0);

        // Misaligned half and illegal size
        d_issue(1'b0, SZ_H, 1'b0, 32'h0000_0201, 32'h0);
        step();
        chk("mis_h_flags", {29'd0, d_gnt, d_misalign, m_req}, 32'd6);
        d_req = 1'b0;
        step();
        d_issue(1'b0, 2'b11, 1'b0, 32'h0000_0200, 32'h0);
        step();
        chk("mis_sz_flags", {29'd0, d_gnt, d_misalign, m_req}, 32'd6);
        d_req = 1'b0;
        step();

        // Simultaneous requests: data first, three wait states, then fetch
        d_issue(1'b0, SZ_W, 1'b0, 32'h0000_0300, 32'h0);
        if_req = 1'b1; if_addr = 32'h0000_0104;
        step();
        chk("pri_d_gnt", 32'(d_gnt), 32'd1);
        chk("pri_if_gnt", 32'(if_gnt), 32'd0);
        chk("pri_m_addr", m_addr, 32'h0000_0300);
        d_req = 1'b0;
        step();
        chk("pri_ws1", {30'd0, m_req, if_gnt}, 32'd2);
        step();
        chk("pri_ws2", {30'd0, m_req, if_gnt}, 32'd2);
        step();
        chk("pri_ws3", {30'd0, m_req, if_gnt}, 32'd2);
        m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
        step();
        chk("pri_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("pri_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("pri_if_wait", {30'd0, m_req, if_gnt}, 32'd0);
        m_ready = 1'b0;
        step();
        chk("pri_if_gnt_late", 32'(if_gnt), 32'd1);
        chk("pri_if_addr", m_addr, 32'h0000_0104);
        if_req = 1'b0; m_ready = 1'b1; m_rdata = 32'h0000_0011;
        step();
        chk("pri_if_rdata", if_rdata, 32'h0000_0011);
        m_ready = 1'b0;

        // Reset in the middle of a data access, late m_ready ignored
        d_issue(1'b0, SZ_W, 1'b0, 32'h0000_0400, 32'h0);
        step();
        chk("rst_mid_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0; rst = 1'b1;
        step();
        chk("rst_mid_m_req", 32'(m_req), 32'd0);
        chk("rst_mid_rvalid", 32'(d_rvalid), 32'd0);
        rst = 1'b0; m_ready = 1'b1; m_rdata = 32'h5555_5555;
        step();
        chk("rst_late_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_late_rdata", d_rdata, 32'd0);
        chk("rst_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        m_ready = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0500;
        step();
        chk("rst_then_fetch", 32'(if_gnt), 32'd1);
        if_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
